// File: rtl/pong_pkg.sv
// Shared Pong constants: UART framing, key codes and the TX state encoding.
package pong_pkg;

  localparam logic        UART_START     = 1'b0;
  localparam logic        UART_STOP      = 1'b1;
  localparam int unsigned UART_DATA_BITS = 8;

  localparam logic [7:0] KEY_UP  = 8'h26;
  localparam logic [7:0] KEY_DWN = 8'h28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one byte per i_start, LSB first, registered line output.
module uart_transmitter
  import pong_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       in_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_active,
  output logic       o_done,
  output logic       o_serial
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // done is registered, so it is armed one cycle before the final stop-bit cycle
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             serial_q;
  logic             done_q;

  // Frame sequencer with registered line and done outputs
  always_ff @(posedge in_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      serial_q <= UART_STOP;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q    <= CNT_ZERO;
          idx_q    <= 3'd0;
          serial_q <= UART_STOP;
          if (i_start) begin
            shift_q  <= i_byte;
            serial_q <= UART_START;
            state_q  <= START;
          end
        end
        START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= CNT_ZERO;
            idx_q    <= 3'd0;
            serial_q <= shift_q[0];
            state_q  <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= CNT_ZERO;
            if (idx_q == IDX_LAST) begin
              serial_q <= UART_STOP;
              state_q  <= STOP;
            end else begin
              idx_q    <= idx_q + 3'd1;
              serial_q <= shift_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          serial_q <= UART_STOP;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_ZERO;
            state_q <= IDLE;
          end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            done_q <= (cnt_q == CNT_PRE);
          end
        end
        default: begin
          cnt_q    <= CNT_ZERO;
          serial_q <= UART_STOP;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign o_active = (state_q != IDLE);
  assign o_done   = done_q;
  assign o_serial = serial_q;

endmodule

// File: rtl/pong_event_tx.sv
// Pong event transmit path: byte FIFO feeding an 8N1 UART transmitter.
module pong_event_tx
  import pong_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       in_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_byte,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_serial
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full_s, empty_s, push_s, pop_s, tx_active_s;

  // Full is taken from the registered count, so a push in a popping cycle is still dropped
  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == CNT_W'(0));
  assign push_s  = i_wr_en && !full_s;
  assign pop_s   = !empty_s && !tx_active_s;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointer registers
  always_ff @(posedge in_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= i_wr_byte;
      end
    end
  end

  uart_transmitter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .in_clk  (in_clk),
    .i_rst   (i_rst),
    .i_start (pop_s),
    .i_byte  (mem_q[rd_ptr_q]),
    .o_active(tx_active_s),
    .o_done  (o_tx_done),
    .o_serial(o_serial)
  );

  assign o_full = full_s;
  assign o_busy = tx_active_s || !empty_s;

endmodule

// File: doc/pong_event_tx.md
# pong_event_tx

Serial transmit path for the Pong game: accepts game-event bytes from game logic, buffers them in a small FIFO, and sends each byte as an 8N1 UART frame on `o_serial`. It pairs with the UART receive path that drives paddle control. It carries score and paddle-key echo codes back to the host terminal, using the same baud timing as the receiver.

## Interface

Parameters:
- `CLKS_PER_BIT`, 434 — `in_clk` cycles per UART bit (50 MHz / 115200); minimum 2.
- `FIFO_DEPTH`, 4 — byte FIFO entries; power of two, ≥2.

Ports:
- `in_clk` input 1 — system clock; all logic on the rising edge.
- `i_rst` input 1 — asynchronous, active-high reset.
- `i_wr_en` input 1 — push strobe; one byte pushed per cycle when high and not full.
- `i_wr_byte` input 8 — byte to push; sampled with `i_wr_en`.
- `o_full` output 1 — FIFO holds `FIFO_DEPTH` bytes.
- `o_busy` output 1 — FIFO non-empty or a frame is in progress.
- `o_tx_done` output 1 — one-cycle pulse when a frame's stop bit completes.
- `o_serial` output 1 — UART TX line; idle high.

## Operation

- Reset values (asynchronous, immediate):
  - `o_serial`=1, `o_busy`=0, `o_full`=0, `o_tx_done`=0.
  - FIFO empty (pointers and count 0), FSM in IDLE, bit counters 0.
- FIFO:
  - Push when `i_wr_en && !o_full`. A push while full is dropped with no state change.
  - `o_full` is derived from the registered count. A push in the same cycle that IDLE pops from a full FIFO is still dropped.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - `o_serial`=1.
    - If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - START:
    - `o_serial`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA:
    - `o_serial` = shift register bit[index], LSB first, for `CLKS_PER_BIT` cycles per bit.
    - After bit 7, go to STOP.
  - STOP:
    - `o_serial`=1 for `CLKS_PER_BIT` cycles.
    - On the last cycle, assert `o_tx_done` for one cycle and go to IDLE.
- `o_busy` = (state != IDLE) || (count != 0).
- Baud counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and reloads 0 on state change.
- A reset asserted mid-frame abandons the frame. The line returns high at once and queued bytes are discarded.
- Input bytes are not filtered; any 8-bit value is transmitted verbatim.
- Shared game codes used by callers: `0x26` (up), `0x28` (down).

## Timing

- Push at edge N: count = 1 after edge N.
- IDLE pops at edge N+1, so `o_serial` falls after edge N+1. The latency from push to start bit is 2 edges.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles from the start-bit falling edge to the end of the stop bit.
- `o_tx_done` is high during the final stop-bit cycle.
- Back-to-back frames: after STOP, one IDLE cycle (line high), then the next start bit. The frame period is therefore 10×`CLKS_PER_BIT`+1.
- `o_full` and `o_busy` update one cycle after the push or pop that changes them.

## Structure

- Shared package `pong_pkg`:
  - UART constants: `UART_START`=0, `UART_STOP`=1, `UART_DATA_BITS`=8.
  - Key codes `KEY_UP`=8'h26, `KEY_DWN`=8'h28.
  - TX state enum (IDLE/START/DATA/STOP).
- Sub-module `uart_transmitter`: the FSM plus baud counter. Handshake is `i_start`/`i_byte` in, `o_active`/`o_done`/`o_serial` out.
- The top level holds the FIFO and connects the FIFO head to `uart_transmitter`.

## Test plan

- Single byte, `CLKS_PER_BIT`=4: push 0x26 → `o_serial` bit sequence 0,0,1,1,0,0,1,0,0,1, each bit held 4 cycles. `o_tx_done` pulses once at cycle 40 of the frame. `o_busy` drops the cycle after.
- Back-to-back: push 0x26 then 0x28 on consecutive cycles → two frames separated by exactly one high cycle. The second frame's data bits are 0,0,0,1,0,1,0,0.
- Overflow, `FIFO_DEPTH`=4: push 6 bytes 0x01..0x06 on consecutive cycles → `o_full`=1. Bytes 0x01..0x05 are transmitted in order and 0x06 is dropped, because 0x01 is popped on the cycle after its push.
- Full plus pop collision: with the FIFO full and IDLE popping, assert `i_wr_en` with 0xAA → byte dropped and count becomes 3.
- Reset mid-frame: assert `i_rst` during DATA bit 3 → `o_serial`=1 immediately, and `o_busy`=0, `o_full`=0. After release, no further frames are sent until a new push.
- Idle line: 100 cycles after reset with no push → `o_serial` constantly 1 and `o_tx_done` never asserted.
